adat_rx_frame_parser: RTL and testbench

Deserialises the decoded ADAT bit stream into per-channel 24-bit samples, user bits and frame timing. It sits directly upstream of `adat_rx_output_interface` and drives that block's `i_frame_time`, `i_data`, `i_channel`, `i_data_valid`, `i_sync` and `i_user_bits`. Input is one NRZ bit per `i_bit_valid` strobe from the bit-recovery stage.

---
 rtl/adat_rx_frame_parser.sv | 169 ++++++++++++++++
 tb/tb_adat_rx_frame_parser.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/adat_rx_frame_parser.sv
// ADAT receive frame parser.
// Turns the recovered NRZ bit stream into per-channel 24-bit samples,
// frame user bits and frame timing. It recognises the zero-run sync,
// checks every nibble separator and tracks lock across frames.
module adat_rx_frame_parser #(
  parameter int SYNC_ZEROS = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bit,
  input  logic        i_bit_valid,
  output logic [23:0] o_data,
  output logic [2:0]  o_channel,
  output logic        o_data_valid,
  output logic [3:0]  o_user_bits,
  output logic [11:0] o_frame_time,
  output logic        o_sync,
  output logic        o_frame_start
);

  localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [4:0]        SYNC_MIN  = 5'(SYNC_ZEROS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  typedef enum logic [1:0] {HUNT, USER, SEP, NIB} state_t;

  state_t            state;
  logic [4:0]        zero_cnt;
  logic [1:0]        bit_cnt;
  logic [2:0]        nib_idx;
  logic [2:0]        chan_idx;
  logic [3:0]        user_sr;
  logic [23:0]       data_sr;
  logic [11:0]       frame_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic              start_hit;
  logic              timeout_hit;
  logic [3:0]        user_next;
  logic [23:0]       data_next;

  assign start_hit   = i_bit_valid && (state == HUNT) && i_bit && (zero_cnt >= SYNC_MIN);
  // The timeout fires on the clock that would take the idle count to TIMEOUT;
  // a strobe in that same clock takes priority.
  assign timeout_hit = !i_bit_valid && (idle_cnt == IDLE_LAST);
  assign user_next   = {user_sr[2:0], i_bit};
  assign data_next   = {data_sr[22:0], i_bit};

  // Payload shift registers: pure data, fully overwritten before every use.
  always_ff @(posedge i_clk) begin
    if (i_bit_valid) begin
      if (state == USER) user_sr <= user_next;
      if (state == NIB)  data_sr <= data_next;
    end
  end

  // Idle counter: clocks since the last bit strobe, saturating at TIMEOUT.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      idle_cnt <= '0;
    end else if (i_bit_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Frame timer: the value latched is the number of clocks between the two
  // most recent frame starts (the start clock itself included), capped at 4095.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      frame_cnt    <= '0;
      o_frame_time <= '0;
    end else if (start_hit) begin
      o_frame_time <= (frame_cnt == 12'hFFF) ? 12'hFFF : frame_cnt + 12'd1;
      frame_cnt    <= '0;
    end else if (frame_cnt != 12'hFFF) begin
      frame_cnt <= frame_cnt + 12'd1;
    end
  end

  // Frame state machine with registered outputs; advances only on bit strobes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= HUNT;
      zero_cnt      <= '0;
      bit_cnt       <= '0;
      nib_idx       <= '0;
      chan_idx      <= '0;
      o_data        <= '0;
      o_channel     <= '0;
      o_data_valid  <= 1'b0;
      o_user_bits   <= '0;
      o_sync        <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_data_valid  <= 1'b0;
      o_frame_start <= 1'b0;
      if (i_bit_valid) begin
        case (state)
          HUNT: begin
            if (!i_bit) begin
              if (zero_cnt != 5'd31) zero_cnt <= zero_cnt + 5'd1;
            end else if (zero_cnt >= SYNC_MIN) begin
              o_frame_start <= 1'b1;
              state         <= USER;
              bit_cnt       <= '0;
              nib_idx       <= '0;
              chan_idx      <= '0;
              zero_cnt      <= '0;
            end else begin
              // A one ending a too-short zero run is a sync error.
              zero_cnt <= '0;
              o_sync   <= 1'b0;
            end
          end
          USER: begin
            bit_cnt <= bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) begin
              o_user_bits <= user_next;
              state       <= SEP;
            end
          end
          SEP: begin
            if (i_bit) begin
              state   <= NIB;
              bit_cnt <= '0;
            end else begin
              // The bad separator is itself the first zero of a new sync run.
              o_sync   <= 1'b0;
              zero_cnt <= 5'd1;
              state    <= HUNT;
            end
          end
          NIB: begin
            bit_cnt <= bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) begin
              if (nib_idx == 3'd5) begin
                o_data       <= data_next;
                o_channel    <= chan_idx;
                o_data_valid <= 1'b1;
                nib_idx      <= '0;
                if (chan_idx == 3'd7) begin
                  o_sync   <= 1'b1;
                  state    <= HUNT;
                  zero_cnt <= '0;
                end else begin
                  chan_idx <= chan_idx + 3'd1;
                  state    <= SEP;
                end
              end else begin
                nib_idx <= nib_idx + 3'd1;
                state   <= SEP;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end else if (timeout_hit) begin
        o_sync   <= 1'b0;
        state    <= HUNT;
        zero_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adat_rx_frame_parser.sv
// Directed bench for adat_rx_frame_parser: builds ADAT frames bit by bit,
// one strobe every 8 clocks, and checks samples, user bits, lock and timing.
module tb_adat_rx_frame_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;

  logic [23:0] data;
  logic [2:0]  channel;
  logic        data_valid;
  logic [3:0]  user_bits;
  logic [11:0] frame_time;
  logic        sync;
  logic        frame_start;

  logic [23:0] sat_data;
  logic [2:0]  sat_channel;
  logic        sat_data_valid;
  logic [3:0]  sat_user_bits;
  logic [11:0] sat_frame_time;
  logic        sat_sync;
  logic        sat_frame_start;

  int          tests = 0;
  int          fails = 0;

  int          n_dv;
  int          n_fs;
  logic [2:0]  got_ch   [16];
  logic [23:0] got_data [16];
  logic        sync_before;
  logic        sync_after;
  logic        dv_last;

  always #5 clk = ~clk;

  adat_rx_frame_parser dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_bit         (bit_in),
    .i_bit_valid   (bit_valid),
    .o_data        (data),
    .o_channel     (channel),
    .o_data_valid  (data_valid),
    .o_user_bits   (user_bits),
    .o_frame_time  (frame_time),
    .o_sync        (sync),
    .o_frame_start (frame_start)
  );

  adat_rx_frame_parser #(.SYNC_ZEROS(10), .TIMEOUT(8192)) dut_sat (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_bit         (bit_in),
    .i_bit_valid   (bit_valid),
    .o_data        (sat_data),
    .o_channel     (sat_channel),
    .o_data_valid  (sat_data_valid),
    .o_user_bits   (sat_user_bits),
    .o_frame_time  (sat_frame_time),
    .o_sync        (sat_sync),
    .o_frame_start (sat_frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},        32'(data),        32'h0);
    check({tag, "_channel"},     32'(channel),     32'h0);
    check({tag, "_data_valid"},  32'(data_valid),  32'h0);
    check({tag, "_user_bits"},   32'(user_bits),   32'h0);
    check({tag, "_frame_time"},  32'(frame_time),  32'h0);
    check({tag, "_sync"},        32'(sync),        32'h0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'h0);
  endtask

  // One strobe, then sample the registered outputs one clock later.
  task automatic send_bit(input logic b);
    @(negedge clk);
    sync_before = sync;
    bit_in      = b;
    bit_valid   = 1'b1;
    @(negedge clk);
    bit_valid   = 1'b0;
    sync_after  = sync;
    dv_last     = data_valid;
    if (frame_start) n_fs++;
    if (data_valid) begin
      if (n_dv < 16) begin
        got_ch[n_dv]   = channel;
        got_data[n_dv] = data;
      end
      n_dv++;
    end
    repeat (6) @(negedge clk);
  endtask

  // Channel n carries 24'hAA000n. bad_nib forces that nibble's separator to 0;
  // stop_nib ends the stream after that nibble (-1 for a full frame).
  task automatic send_frame(input logic [3:0] user, input int nzeros,
                            input int bad_nib, input int stop_nib);
    int last;
    logic [23:0] word;
    n_dv = 0;
    n_fs = 0;
    last = (stop_nib < 0) ? 48 : stop_nib + 1;
    for (int i = 0; i < nzeros; i++) send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 3; i >= 0; i--) send_bit(user[i]);
    for (int nib = 0; nib < last; nib++) begin
      word = 24'hAA0000 | 24'(nib / 6);
      send_bit((nib == bad_nib) ? 1'b0 : 1'b1);
      for (int m = 0; m < 4; m++) send_bit(word[23 - 4 * (nib % 6) - m]);
    end
  endtask

  task automatic check_frame(input string tag, input logic [3:0] user);
    check({tag, "_frame_starts"}, 32'(n_fs), 32'd1);
    check({tag, "_dv_count"},     32'(n_dv), 32'd8);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("%s_ch%0d_index", tag, c), 32'(got_ch[c]),   32'(c));
      check($sformatf("%s_ch%0d_data", tag, c),  32'(got_data[c]), 32'h00AA0000 | 32'(c));
    end
    check({tag, "_user_bits"},  32'(user_bits),  32'(user));
    check({tag, "_sync_end"},   32'(sync_after), 32'd1);
    check({tag, "_sync_w_dv7"}, 32'(dv_last),    32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("post_rst");

    // Clean frames: lock after the first complete frame.
    send_frame(4'b0010, 11, -1, -1);
    check("f1_sync_before_last", 32'(sync_before), 32'd0);
    check_frame("f1", 4'b0010);
    for (int f = 2; f <= 5; f++) begin
      send_frame(4'b0010, 11, -1, -1);
      check_frame($sformatf("f%0d", f), 4'b0010);
      check($sformatf("f%0d_frame_time", f), 32'(frame_time), 32'd2048);
    end
    check("hold_data",    32'(data),       32'h00AA0007);
    check("hold_channel", 32'(channel),    32'd7);
    check("hold_dv_low",  32'(data_valid), 32'd0);

    // Short sync: nine zeros then a one.
    n_fs = 0;
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    send_bit(1'b1);
    check("short_sync_drop", 32'(sync), 32'd0);
    check("short_sync_nofs", 32'(n_fs), 32'd0);
    send_frame(4'b1001, 11, -1, -1);
    check("short_relock_late", 32'(sync_before), 32'd0);
    check_frame("short_relock", 4'b1001);

    // Separator error before channel 3 nibble 2.
    send_frame(4'b0110, 11, 20, -1);
    check("seperr_sync",     32'(sync), 32'd0);
    check("seperr_dv_count", 32'(n_dv), 32'd3);
    for (int c = 0; c < 3; c++)
      check($sformatf("seperr_ch%0d", c), 32'(got_ch[c]), 32'(c));
    send_frame(4'b0110, 11, -1, -1);
    check("seperr_relock_late", 32'(sync_before), 32'd0);
    check_frame("seperr_relock", 4'b0110);

    // Long gap between frame starts: frame time saturates.
    repeat (5000) @(negedge clk);
    check("sat_gap_timeout", 32'(sync),     32'd0);
    check("sat_gap_nolimit", 32'(sat_sync), 32'd1);
    send_frame(4'b1111, 11, -1, -1);
    check("sat_frame_time",      32'(frame_time),     32'd4095);
    check("sat_frame_time_long", 32'(sat_frame_time), 32'd4095);
    check_frame("sat", 4'b1111);

    // Timeout mid-frame.
    send_frame(4'b0010, 11, -1, 9);
    check("to_locked_mid", 32'(sync), 32'd1);
    repeat (70) @(negedge clk);
    check("to_sync_drop", 32'(sync), 32'd0);
    send_frame(4'b0100, 11, -1, -1);
    check("to_relock_late", 32'(sync_before), 32'd0);
    check_frame("to_relock", 4'b0100);

    // Reset mid-frame clears outputs without waiting for a clock.
    send_frame(4'b0010, 11, -1, 20);
    check("midrst_pre_data", 32'(data), 32'h00AA0002);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(4'b0011, 11, -1, -1);
    check("midrst_relock_late", 32'(sync_before), 32'd0);
    check_frame("midrst_relock", 4'b0011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
